// File: rtl/matmul_tile_sched.sv
// Tile-loop sequencer for the fixed-size vector multiplier: walks output tiles (i,j)
// and reduction index k, handshaking the tile loader, the engine and the tile store.
module matmul_tile_sched #(
  parameter int TILE_BITS = 6,
  parameter int CNT_BITS  = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [TILE_BITS-1:0] cfg_ntiles,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ld_req,
  input  logic                 ld_ack,
  output logic [TILE_BITS-1:0] tile_i,
  output logic [TILE_BITS-1:0] tile_j,
  output logic [TILE_BITS-1:0] tile_k,
  output logic                 mul_start,
  input  logic                 mul_done,
  output logic                 acc_first,
  output logic                 st_req,
  input  logic                 st_ack,
  output logic [CNT_BITS-1:0]  tiles_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MSTART, S_MWAIT, S_STORE, S_NEXT, S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [TILE_BITS-1:0] ntiles_q, ntiles_d;
  logic [TILE_BITS-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [CNT_BITS-1:0]  tiles_done_q, tiles_done_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 ld_req_q, ld_req_d, st_req_q, st_req_d;
  logic                 mul_start_q, mul_start_d, acc_first_q, acc_first_d;
  logic [TILE_BITS-1:0] last;

  assign last = ntiles_q - TILE_BITS'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    ntiles_d     = ntiles_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    tiles_done_d = tiles_done_q;
    busy_d       = busy_q;
    err_d        = err_q;
    done_d       = 1'b0;
    ld_req_d     = 1'b0;
    st_req_d     = 1'b0;
    mul_start_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_ntiles == '0) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            ntiles_d     = cfg_ntiles;
            i_d          = '0;
            j_d          = '0;
            k_d          = '0;
            tiles_done_d = '0;
            err_d        = 1'b0;
            busy_d       = 1'b1;
            ld_req_d     = 1'b1;
            state_d      = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (ld_ack) begin
          mul_start_d = 1'b1;
          state_d     = S_MSTART;
        end else begin
          ld_req_d = 1'b1;
        end
      end
      S_MSTART: state_d = S_MWAIT;
      S_MWAIT: begin
        if (mul_done) begin
          if (k_q == last) begin
            st_req_d = 1'b1;
            state_d  = S_STORE;
          end else begin
            k_d      = k_q + TILE_BITS'(1);
            ld_req_d = 1'b1;
            state_d  = S_LOAD;
          end
        end
      end
      S_STORE: begin
        if (st_ack) begin
          tiles_done_d = tiles_done_q + CNT_BITS'(1);
          state_d      = S_NEXT;
        end else begin
          st_req_d = 1'b1;
        end
      end
      S_NEXT: begin
        k_d = '0;
        if (j_q < last) begin
          j_d      = j_q + TILE_BITS'(1);
          ld_req_d = 1'b1;
          state_d  = S_LOAD;
        end else begin
          j_d = '0;
          if (i_q < last) begin
            i_d      = i_q + TILE_BITS'(1);
            ld_req_d = 1'b1;
            state_d  = S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including an ack or mul_done arriving in the same cycle.
    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      i_d          = i_q;
      j_d          = j_q;
      k_d          = k_q;
      tiles_done_d = tiles_done_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      ld_req_d     = 1'b0;
      st_req_d     = 1'b0;
      mul_start_d  = 1'b0;
    end

    acc_first_d = (state_d == S_LOAD || state_d == S_MSTART || state_d == S_MWAIT) && (k_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ntiles_q     <= '0;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      tiles_done_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ld_req_q     <= 1'b0;
      st_req_q     <= 1'b0;
      mul_start_q  <= 1'b0;
      acc_first_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q      <= state_d;
      ntiles_q     <= ntiles_d;
      i_q          <= i_d;
      j_q          <= j_d;
      k_q          <= k_d;
      tiles_done_q <= tiles_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ld_req_q     <= ld_req_d;
      st_req_q     <= st_req_d;
      mul_start_q  <= mul_start_d;
      acc_first_q  <= acc_first_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ld_req     = ld_req_q;
  assign st_req     = st_req_q;
  assign mul_start  = mul_start_q;
  assign acc_first  = acc_first_q;
  assign tile_i     = i_q;
  assign tile_j     = j_q;
  assign tile_k     = k_q;
  assign tiles_done = tiles_done_q;

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Self-checking bench for matmul_tile_sched: randomized loader/engine/store responders,
// event monitor, and a loop-nest reference model of the expected tile schedule.
module tb_matmul_tile_sched;
  localparam int TB = 6;
  localparam int CB = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_start = 1'b0;
  logic [TB-1:0] cfg_ntiles = '0;
  logic          abort = 1'b0;
  logic          busy, done, err, ld_req, ld_ack, mul_start, mul_done, acc_first, st_req, st_ack;
  logic [TB-1:0] tile_i, tile_j, tile_k;
  logic [CB-1:0] tiles_done;

  logic resp_ld_ack = 1'b0, resp_mul_done = 1'b0, resp_st_ack = 1'b0;
  logic tb_ld_ack = 1'b0, tb_mul_done = 1'b0, tb_st_ack = 1'b0;
  assign ld_ack   = resp_ld_ack | tb_ld_ack;
  assign mul_done = resp_mul_done | tb_mul_done;
  assign st_ack   = resp_st_ack | tb_st_ack;

  matmul_tile_sched #(.TILE_BITS(TB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ntiles(cfg_ntiles), .abort(abort),
    .busy(busy), .done(done), .err(err), .ld_req(ld_req), .ld_ack(ld_ack),
    .tile_i(tile_i), .tile_j(tile_j), .tile_k(tile_k), .mul_start(mul_start),
    .mul_done(mul_done), .acc_first(acc_first), .st_req(st_req), .st_ack(st_ack),
    .tiles_done(tiles_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Responder latency ranges, set by the main sequence.
  int ld_min = 0, ld_max = 0, st_min = 0, st_max = 0, eng_min = 1, eng_max = 1;
  bit st_hold = 1'b0;

  initial begin
    int ld_wait = 0, st_wait = 0, eng_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (ld_req && !resp_ld_ack) begin
        if (ld_wait <= 0) resp_ld_ack = 1'b1; else ld_wait--;
      end else begin
        resp_ld_ack = 1'b0;
        ld_wait = int'($urandom_range(ld_max, ld_min));
      end
      if (st_req && !resp_st_ack && !st_hold) begin
        if (st_wait <= 0) resp_st_ack = 1'b1; else st_wait--;
      end else begin
        resp_st_ack = 1'b0;
        st_wait = int'($urandom_range(st_max, st_min));
      end
      resp_mul_done = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) resp_mul_done = 1'b1;
      end
      if (mul_start) eng_cnt = int'($urandom_range(eng_max, eng_min));
    end
  end

  // Monitor: logs request coordinates, engine starts and protocol violations.
  logic [31:0] ld_log[$];
  logic [31:0] st_log[$];
  bit          acc_log[$];
  int mul_cnt = 0, done_cnt = 0, busy_cyc = 0, unstable = 0, drop_noack = 0, bad_pulse = 0;

  initial begin
    logic [31:0] cur, ld_hold, st_hold_c;
    bit ld_p = 0, st_p = 0, ms_p = 0, dn_p = 0, lda_p = 0, sta_p = 0;
    ld_hold = '0;
    st_hold_c = '0;
    forever begin
      @(posedge clk); #2;
      cur = {14'd0, tile_i, tile_j, tile_k};
      if (ld_req && !ld_p) begin ld_log.push_back(cur); ld_hold = cur; end
      else if (ld_req && cur != ld_hold) unstable++;
      if (st_req && !st_p) begin st_log.push_back(cur >> TB); st_hold_c = cur; end
      else if (st_req && cur != st_hold_c) unstable++;
      if (ld_p && !ld_req && !lda_p && !abort && rst) drop_noack++;
      if (st_p && !st_req && !sta_p && !abort && rst) drop_noack++;
      if (mul_start) begin
        mul_cnt++;
        acc_log.push_back(acc_first);
        if (ms_p) bad_pulse++;
      end
      if (done) begin done_cnt++; if (dn_p) bad_pulse++; end
      if (busy) busy_cyc++;
      ld_p = ld_req; st_p = st_req; ms_p = mul_start; dn_p = done;
      lda_p = ld_ack; sta_p = st_ack;
    end
  end

  task automatic start_job(input int n);
    @(negedge clk);
    cfg_ntiles = TB'(n);
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
    cfg_ntiles = TB'($urandom);
  endtask

  task automatic wait_st_req();
    for (int c = 0; c < 2000 && !st_req; c++) @(negedge clk);
    check("st_req_wait", st_req, 1);
  endtask

  // Full job compared against the i/j/k loop-nest model.
  task automatic run_job(input int n, input bit stray_start);
    int lb = ld_log.size(), sb = st_log.size(), ab = acc_log.size();
    int m0 = mul_cnt, d0 = done_cnt, u0 = unstable, q0 = drop_noack, p0 = bad_pulse;
    logic [31:0] exp_ld[$];
    logic [31:0] exp_st[$];
    bit          exp_acc[$];
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        for (int k = 0; k < n; k++) begin
          exp_ld.push_back(32'(i * 4096 + j * 64 + k));
          exp_acc.push_back(k == 0);
        end
        exp_st.push_back(32'(i * 64 + j));
      end
    start_job(n);
    check("busy_on", busy, 1);
    check("err_clr", err, 0);
    if (stray_start) begin
      repeat (2) @(negedge clk);
      if (busy) begin
        cfg_ntiles = TB'(5);
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
      end
    end
    for (int c = 0; c < 20000 && done_cnt == d0; c++) @(negedge clk);
    check("done_cnt", done_cnt - d0, 1);
    @(negedge clk);
    check("busy_off", busy, 0);
    check("done_pulse", done, 0);
    check("tiles_done", tiles_done, n * n);
    check("err_job", err, 0);
    check("ld_count", ld_log.size() - lb, n * n * n);
    check("mul_count", mul_cnt - m0, n * n * n);
    check("st_count", st_log.size() - sb, n * n);
    foreach (exp_ld[x])
      check("ld_coord", (lb + x < ld_log.size()) ? ld_log[lb + x] : 32'hFFFF_FFFF, exp_ld[x]);
    foreach (exp_acc[x])
      check("acc_first", (ab + x < acc_log.size()) ? 32'(acc_log[ab + x]) : 32'hFFFF_FFFF, 32'(exp_acc[x]));
    foreach (exp_st[x])
      check("st_coord", (sb + x < st_log.size()) ? st_log[sb + x] : 32'hFFFF_FFFF, exp_st[x]);
    check("req_stable", unstable - u0, 0);
    check("req_drop_noack", drop_noack - q0, 0);
    check("pulse_width", bad_pulse - p0, 0);
  endtask

  initial begin
    int d0, m0, l0, b0;

    repeat (2) @(negedge clk);
    check("rst_ctrl", {busy, done, err, ld_req, st_req, mul_start, acc_first}, 0);
    check("rst_coord", {tile_i, tile_j, tile_k}, 0);
    check("rst_cnt", tiles_done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single tile, immediate acks, 4-cycle engine.
    ld_min = 0; ld_max = 0; st_min = 0; st_max = 0; eng_min = 4; eng_max = 4;
    run_job(1, 0);

    // Two tiles per dimension, fastest possible engine.
    eng_min = 1; eng_max = 1;
    run_job(2, 0);

    // Slow acks, varying engine latency, stray start while busy.
    ld_min = 5; ld_max = 5; st_min = 3; st_max = 3; eng_min = 1; eng_max = 3;
    run_job(2, 1);

    // Zero-tile start sets err without running; next start clears it.
    ld_min = 0; ld_max = 1; st_min = 0; st_max = 1;
    d0 = done_cnt; b0 = busy_cyc; l0 = ld_log.size();
    start_job(0);
    check("zero_err", err, 1);
    check("zero_done", done, 1);
    repeat (4) @(negedge clk);
    check("zero_done_cnt", done_cnt - d0, 1);
    check("zero_busy", busy_cyc - b0, 0);
    check("zero_ld", ld_log.size() - l0, 0);
    check("zero_err_sticky", err, 1);
    run_job(1, 0);

    // Abort in MWAIT of the third k-step; the late mul_done must be ignored.
    eng_min = 6; eng_max = 6;
    d0 = done_cnt; m0 = mul_cnt; l0 = ld_log.size();
    start_job(3);
    for (int c = 0; c < 2000 && mul_cnt - m0 < 3; c++) @(negedge clk);
    check("abort_k", tile_k, 2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ld", ld_req, 0);
    check("abort_cnt", tiles_done, 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", {busy, ld_req, st_req}, 0);
    check("abort_mul", mul_cnt - m0, 3);
    check("abort_ld_cnt", ld_log.size() - l0, 3);
    eng_min = 1; eng_max = 4;
    run_job(2, 0);

    // Abort coinciding with st_ack: no increment.
    st_hold = 1'b1;
    d0 = done_cnt;
    start_job(1);
    wait_st_req();
    tb_st_ack = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    tb_st_ack = 1'b0;
    abort     = 1'b0;
    check("ab_ack_cnt", tiles_done, 0);
    check("ab_ack_idle", {busy, st_req}, 0);
    repeat (2) @(negedge clk);
    check("ab_ack_done", done_cnt - d0, 0);

    // Asynchronous reset while a store is pending.
    start_job(2);
    wait_st_req();
    check("store_k", tile_k, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_ctrl", {busy, st_req, ld_req}, 0);
    check("arst_coord", {tile_i, tile_j, tile_k}, 0);
    check("arst_cnt", tiles_done, 0);
    @(negedge clk);
    rst = 1'b1;
    st_hold = 1'b0;

    // Stray engine/ack pulses while idle.
    d0 = done_cnt; m0 = mul_cnt; l0 = ld_log.size();
    @(negedge clk);
    tb_mul_done = 1'b1; tb_ld_ack = 1'b1; tb_st_ack = 1'b1;
    @(negedge clk);
    tb_mul_done = 1'b0; tb_ld_ack = 1'b0; tb_st_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_idle", {busy, ld_req, st_req, done, err}, 0);
    check("stray_mul", mul_cnt - m0, 0);
    check("stray_ld", ld_log.size() - l0, 0);
    check("stray_done", done_cnt - d0, 0);

    // Randomized jobs.
    for (int r = 0; r < 4; r++) begin
      ld_min = 0; ld_max = int'($urandom_range(4, 0));
      st_min = 0; st_max = int'($urandom_range(4, 0));
      eng_min = 1; eng_max = int'($urandom_range(5, 1));
      run_job(int'($urandom_range(3, 1)), bit'($urandom_range(1, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/matmul_tile_sched.md
Name: matmul_tile_sched

Overview:
- Sequences the fixed MUL_SIZE x MUL_SIZE vector multiplier engine through a tiled multiply of an N x N matrix, where N = ntiles * MUL_SIZE.
- Walks output tiles (i,j) and, for each, the reduction index k. Per step it handshakes a tile loader, pulses the engine start, waits for its done, and flags first/accumulate.
- After the last k of a tile it requests a store of the output tile.
- Sits between the MMIO control register and the engine/DMA staging logic in the accelerator top level.

Parameters:
- TILE_BITS, 6, width of tile index and tile count (max 63 tiles per dimension)
- CNT_BITS, 18, width of completed-output-tile counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_ntiles  in  TILE_BITS  tiles per dimension; captured on accepted start
- abort  in  1  cancel running job
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky; set on start with ntiles==0; cleared by next accepted start
- ld_req  out  1  load request for A tile (i,k) and B tile (k,j)
- ld_ack  in  1  loader acknowledge
- tile_i, tile_j, tile_k  out  TILE_BITS each  current tile coordinates
- mul_start  out  1  one-cycle engine start pulse
- mul_done  in  1  engine completion pulse
- acc_first  out  1  high when k==0 (output partial overwritten, not accumulated); valid from mul_start through mul_done
- st_req  out  1  store request for output tile (i,j)
- st_ack  in  1  store acknowledge
- tiles_done  out  CNT_BITS  count of output tiles stored in current job

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; i=j=k=0; ntiles register 0.
- States: IDLE, LOAD, MSTART, MWAIT, STORE, NEXT, FIN.
- IDLE: on cfg_start:
  - ntiles==0: err<=1, done pulses next cycle, busy stays 0.
  - Otherwise: capture ntiles, i=j=k=0, tiles_done=0, err<=0, busy<=1, go LOAD.
- LOAD: ld_req=1 with tile_i/j/k stable. When ld_ack sampled high: ld_req<=0, go MSTART.
- MSTART: mul_start=1 for exactly one cycle, go MWAIT. Engine latency is not assumed.
- MWAIT: wait for mul_done.
  - k==ntiles-1: go STORE.
  - Otherwise: k<=k+1, go LOAD.
- STORE: st_req=1 with tile_i/j stable; tile_k holds ntiles-1. On st_ack: st_req<=0, tiles_done<=tiles_done+1, go NEXT.
- NEXT: k<=0.
  - j<ntiles-1: j<=j+1.
  - Else j<=0; then if i<ntiles-1: i<=i+1, else go FIN.
  - Non-final: go LOAD.
- FIN: done=1 one cycle, busy<=0, go IDLE. Coordinates hold final values.
- Handshake rules:
  - A req stays high until its ack is sampled; deassertion is the cycle after ack.
  - Ack in the same cycle req first rises is valid (ack may be combinational).
  - Ack while req low is ignored.
- Stray inputs: mul_done outside MWAIT is ignored. cfg_start while busy is ignored; no restart, no err.
- Abort: abort high in any non-IDLE state goes to IDLE next cycle.
  - ld_req, st_req and busy drop; done does not pulse; tiles_done holds.
  - An engine operation in flight is abandoned; its later mul_done is ignored.
- Simultaneous events:
  - abort and ack in the same cycle: abort wins, and tiles_done is not incremented.
  - cfg_start and abort in IDLE: start accepted.
- Step counts: total engine operations = ntiles^3; stores = ntiles^2.
- Minimum cycles per k-step with immediate acks and 1-cycle engine = 3 (LOAD, MSTART, MWAIT).
- Reset mid-job: immediate return to reset values, regardless of handshakes outstanding.

Test Plan:
- ntiles=1, immediate acks, mul_done 4 cycles after start -> exactly 1 ld_req (0,0,0), 1 mul_start with acc_first=1, 1 st_req (0,0), done pulse, tiles_done=1, busy low after done.
- ntiles=2 -> ld coordinates in order (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0),...,(1,1,1); acc_first alternates 1,0; st_req sequence (0,0),(0,1),(1,0),(1,1); 8 mul_starts; tiles_done=4.
- ld_ack delayed 5 cycles and st_ack delayed 3 cycles, ntiles=2 -> ld_req/st_req held high with stable coordinates until ack; no extra mul_start; same final counts.
- cfg_start with ntiles=0 -> err=1, done pulse, busy never high, no ld_req; next start with ntiles=1 clears err.
- abort asserted in MWAIT of the third k-step (ntiles=3), then a late mul_done -> busy=0 next cycle, no done pulse, tiles_done=0; late mul_done ignored; a fresh start runs a full job normally.
- rst asserted low asynchronously mid-STORE with st_req high -> st_req, busy, and tile_i/j/k drop to 0 without waiting for a clock edge; stray cfg_start, mul_done and acks while busy/idle cause no state change.
